// File: rtl/grant_capture_fifo_if.sv
// Arbiter-facing and downstream-facing handshake bundle for grant_capture_fifo.
// master = the environment that drives grants and consumes the output; slave = the FIFO.
interface grant_capture_fifo_if #(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = 8
);
    localparam int ID_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [NUM_REQUESTERS-1:0]            grant;
    logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
    logic                                 arb_ready;
    logic [NUM_REQUESTERS-1:0]            ack;
    logic                                 out_valid;
    logic [DATA_WIDTH-1:0]                out_data;
    logic [ID_WIDTH-1:0]                  out_id;
    logic                                 out_ready;

    modport master (
        output grant, req_data, out_ready,
        input  arb_ready, ack, out_valid, out_data, out_id
    );
    modport slave (
        input  grant, req_data, out_ready,
        output arb_ready, ack, out_valid, out_data, out_id
    );
endinterface

// File: rtl/grant_capture_fifo.sv
// Captures the arbiter's one-hot grant (index + winning payload) into a small FIFO,
// pulses a per-requester ack and presents the head on a valid/ready port.
module grant_capture_fifo #(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    localparam int ID_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_W    = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    grant_capture_fifo_if.slave   bus,
    output logic [CNT_W-1:0]      count,
    output logic                  onehot_err
);
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_data_q;
    logic [FIFO_DEPTH-1:0][ID_WIDTH-1:0]   mem_id_q;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [NUM_REQUESTERS-1:0] ack_q, ack_d;
    logic                      err_q, err_d;

    logic [ID_WIDTH-1:0]   sel_id;
    logic [DATA_WIDTH-1:0] sel_data;
    logic multi, legal, full, push, pop;

    // OR-reduce over the grant lanes: exact for a one-hot grant, ignored otherwise.
    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (bus.grant[i]) begin
                sel_id   = sel_id | ID_WIDTH'(i);
                sel_data = sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign multi = |(bus.grant & (bus.grant - NUM_REQUESTERS'(1)));
    assign legal = (|bus.grant) && !multi;
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push  = legal && !full;
    assign pop   = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ack_d    = push ? bus.grant : '0;
        err_d    = err_q | multi;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= sel_data;
            mem_id_q[wr_ptr_q]   <= sel_id;
        end
    end

    assign bus.arb_ready = !full;
    assign bus.ack       = ack_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_data_q[rd_ptr_q];
    assign bus.out_id    = mem_id_q[rd_ptr_q];
    assign count         = count_q;
    assign onehot_err    = err_q;
endmodule

// File: tb/tb_grant_capture_fifo.sv
// Directed bench for grant_capture_fifo: stimulus pushes expected {id,data} into a
// scoreboard queue; a negedge monitor pops and compares on every output handshake.
module tb_grant_capture_fifo;
    localparam int NR = 4, DW = 8, FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] count;
    logic onehot_err;
    int tests = 0, fails = 0;
    logic [9:0] exp_q[$];

    grant_capture_fifo_if #(.NUM_REQUESTERS(NR), .DATA_WIDTH(DW)) bus ();

    grant_capture_fifo #(.NUM_REQUESTERS(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: a handshake seen at negedge is consumed at the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {22'd0, bus.out_id, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("pop_id_data", {22'd0, bus.out_id, bus.out_data}, {22'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] g, input int lane, input logic [7:0] d);
        bus.grant = g;
        bus.req_data = 32'($urandom);
        bus.req_data[lane*DW +: DW] = d;
    endtask

    task automatic expect_push(input int lane, input logic [7:0] d);
        exp_q.push_back({2'(lane), d});
    endtask

    initial begin
        int mcount;
        bus.grant = '0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_err", 32'(onehot_err), 0);
        chk("rst_arb_ready", 32'(bus.arb_ready), 1);
        #10 rst_n = 1'b1;

        // 1: single grant, immediate drain
        bus.out_ready = 1'b1;
        drive(4'b0100, 2, 8'hA5); expect_push(2, 8'hA5);
        step();
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_data", 32'(bus.out_data), 32'hA5);
        chk("t1_id", 32'(bus.out_id), 2);
        chk("t1_ack", 32'(bus.ack), 32'b0100);
        chk("t1_count", 32'(count), 1);
        drive(4'b0000, 0, 8'h00);
        step();
        chk("t1_ack_off", 32'(bus.ack), 0);
        chk("t1_count_0", 32'(count), 0);

        // 2: fill to full, drop grant while full, drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'(1 << i), i, 8'(8'h11 * (i + 1)));
            expect_push(i, 8'(8'h11 * (i + 1)));
            step();
        end
        chk("t2_count_full", 32'(count), 4);
        chk("t2_arb_ready", 32'(bus.arb_ready), 0);
        drive(4'b0001, 0, 8'h55);
        step();
        chk("t2_drop_ack", 32'(bus.ack), 0);
        chk("t2_drop_count", 32'(count), 4);
        drive(4'b0000, 0, 8'h00);
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("t2_drained", 32'(count), 0);
        chk("t2_arb_ready_back", 32'(bus.arb_ready), 1);

        // 3: simultaneous push and pop at count 2
        bus.out_ready = 1'b0;
        drive(4'b0001, 0, 8'h66); expect_push(0, 8'h66); step();
        drive(4'b1000, 3, 8'h99); expect_push(3, 8'h99); step();
        chk("t3_count2", 32'(count), 2);
        bus.out_ready = 1'b1;
        drive(4'b0010, 1, 8'h77); expect_push(1, 8'h77);
        step();
        chk("t3_count_same", 32'(count), 2);
        chk("t3_ack", 32'(bus.ack), 32'b0010);
        chk("t3_head", {24'd0, bus.out_data}, 32'h99);
        chk("t3_head_id", 32'(bus.out_id), 3);
        drive(4'b0000, 0, 8'h00);
        repeat (2) step();
        chk("t3_drained", 32'(count), 0);

        // 4: illegal multi-bit grant
        bus.out_ready = 1'b0;
        drive(4'b0011, 0, 8'hEE);
        step();
        chk("t4_err", 32'(onehot_err), 1);
        chk("t4_ack", 32'(bus.ack), 0);
        chk("t4_count", 32'(count), 0);
        drive(4'b0001, 0, 8'h5A); expect_push(0, 8'h5A);
        step();
        chk("t4_legal_ack", 32'(bus.ack), 32'b0001);
        chk("t4_legal_count", 32'(count), 1);
        drive(4'b0000, 0, 8'h00);
        step();
        chk("t4_err_sticky", 32'(onehot_err), 1);

        // 5: async reset mid-cycle with three entries
        drive(4'b0100, 2, 8'hB1); expect_push(2, 8'hB1); step();
        drive(4'b1000, 3, 8'hB2); expect_push(3, 8'hB2); step();
        drive(4'b0000, 0, 8'h00);
        chk("t5_count3", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(bus.out_valid), 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_ack", 32'(bus.ack), 0);
        chk("t5_err", 32'(onehot_err), 0);
        exp_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        step(); step();
        chk("t5_post_valid", 32'(bus.out_valid), 0);
        chk("t5_post_ack", 32'(bus.ack), 0);
        drive(4'b0010, 1, 8'hC3); expect_push(1, 8'hC3);
        step();
        chk("t5_first_data", 32'(bus.out_data), 32'hC3);
        chk("t5_first_id", 32'(bus.out_id), 1);
        drive(4'b0000, 0, 8'h00);
        bus.out_ready = 1'b1;
        step();
        chk("t5_drained", 32'(count), 0);

        // 6: interleaved pushes/pops with random lanes, pointers wrap
        mcount = 0;
        for (int i = 0; i < 10; i++) begin
            int lane;
            logic [7:0] d;
            logic acc, pp;
            lane = int'($urandom_range(3, 0));
            d = 8'($urandom);
            bus.out_ready = (i % 3) != 2;
            drive(4'(1 << lane), lane, d);
            acc = (mcount != FD);
            pp = (mcount != 0) && bus.out_ready;
            if (acc) expect_push(lane, d);
            step();
            mcount = mcount + int'(acc) - int'(pp);
            chk("t6_ack", 32'(bus.ack), acc ? 32'(1 << lane) : 0);
            chk("t6_count", 32'(count), 32'(mcount));
        end
        drive(4'b0000, 0, 8'h00);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && mcount != 0; k++) begin
            step();
            mcount--;
        end
        step();
        chk("t6_empty", 32'(count), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
